multicycle_control: RTL and testbench

//  Main control FSM for the multicycle CPU. Sequences fetch/decode/execute/memory/writeback, drives every datapath enable
//  and mux select, and owns PCSource for the PC-source mux (0=ALU result, 1=ALUOut, 2={6'b0,jump addr}).

---
 rtl/multicycle_control.sv | 177 +++++++++++++++++
 tb/tb_multicycle_control.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath control line.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  state_t state_q, state_d;

  // Zero only qualifies PCWriteCond inside the datapath; the FSM never branches on it.
  logic unused_zero;
  assign unused_zero = Zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (Op == OP_LW || Op == OP_SW) begin
          state_d = S_MEMADR;
        end else if (Op == OP_RTYPE) begin
          state_d = S_EXECUTE;
        end else if (Op == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (Op == OP_J) begin
          state_d = S_JUMP;
        end else if (Op == OP_ADDI) begin
          state_d = S_ADDIEX;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMADR:   state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs decode from state; mem_ready gates only the PC/IR load in FETCH and
  // completion of a store, and Op only flags an illegal opcode in DECODE.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'd0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = 2'd0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'd1;
          PCWrite = mem_ready;
          IRWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'd3;
          if (!(Op == OP_LW || Op == OP_SW || Op == OP_RTYPE ||
                Op == OP_BEQ || Op == OP_J || Op == OP_ADDI)) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_MEMADR, S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
        end
        S_MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'd2;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'd1;
          PCWriteCond = 1'b1;
          PCSource    = 2'd1;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'd2;
          instr_done = 1'b1;
        end
        S_ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: steps each instruction class cycle by
// cycle and compares the full control word against hand-derived vectors.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  // Control word: {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite,
  //                MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,instr_done,illegal_op}
  logic [17:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op};

  function automatic logic [17:0] cv(input logic pcw, input logic pcc, input logic [1:0] pcs,
                                     input logic iord, input logic mr, input logic mw,
                                     input logic irw, input logic m2r, input logic rd,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic done, input logic ill);
    return {pcw, pcc, pcs, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, done, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply mem_ready for one cycle, check outputs before the edge, then advance.
  task automatic cyc(input string tag, input logic rdy, input logic [17:0] exp);
    mem_ready = rdy;
    #1;
    check(tag, {14'd0, ctrl}, {14'd0, exp});
    check({tag, "_mrmw"}, {31'd0, MemRead & MemWrite}, 32'd0);
    check({tag, "_pcx"}, {31'd0, PCWrite & PCWriteCond}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [17:0] E_RST, E_F0, E_F1, E_DEC, E_ILL, E_ADR, E_MRD, E_MWB;
  logic [17:0] E_MW0, E_MW1, E_EXE, E_AWB, E_BR, E_JMP, E_IWB;

  initial begin
    //           pcw  pcc  pcs   iord mr   mw   irw  m2r  rd   rw   asa  asb   aop   done ill
    E_RST = '0;
    E_F0  = cv(1'b0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,1'b0,1'b0);
    E_F1  = cv(1'b1,1'b0,2'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,1'b0,1'b0);
    E_DEC = cv(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd0,1'b0,1'b0);
    E_ILL = cv(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd0,1'b1,1'b1);
    E_ADR = cv(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,1'b0,1'b0);
    E_MRD = cv(1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0);
    E_MWB = cv(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,1'b1,1'b0);
    E_MW0 = cv(1'b0,1'b0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0);
    E_MW1 = cv(1'b0,1'b0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,1'b0);
    E_EXE = cv(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd2,1'b0,1'b0);
    E_AWB = cv(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,1'b1,1'b0);
    E_BR  = cv(1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,1'b1,1'b0);
    E_JMP = cv(1'b1,1'b0,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,1'b0);
    E_IWB = cv(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,1'b1,1'b0);

    reset = 1'b1; Op = 6'h23; Zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    cyc("rst_a", 1'b1, E_RST);
    cyc("rst_b", 1'b0, E_RST);
    reset = 1'b0;

    // Load stalled in MEMREAD, then reset held for three cycles.
    Op = 6'h23;
    cyc("t1_fetch_wait", 1'b0, E_F0);
    cyc("t1_fetch",      1'b1, E_F1);
    cyc("t1_decode",     1'b1, E_DEC);
    cyc("t1_memadr",     1'b1, E_ADR);
    cyc("t1_memrd_wait", 1'b0, E_MRD);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("t1_rst%0d", i), 1'b1, E_RST);
    reset = 1'b0;
    cyc("t1_fetch_wait2", 1'b0, E_F0);

    // Load word with memory always ready: 5 cycles.
    cyc("t2_fetch",  1'b1, E_F1);
    cyc("t2_decode", 1'b1, E_DEC);
    cyc("t2_memadr", 1'b1, E_ADR);
    cyc("t2_memrd",  1'b1, E_MRD);
    cyc("t2_memwb",  1'b1, E_MWB);

    // Store word with two wait cycles in MEMWRITE.
    Op = 6'h2B;
    cyc("t3_fetch",  1'b1, E_F1);
    cyc("t3_decode", 1'b1, E_DEC);
    cyc("t3_memadr", 1'b1, E_ADR);
    cyc("t3_memwr0", 1'b0, E_MW0);
    cyc("t3_memwr1", 1'b0, E_MW0);
    cyc("t3_memwr2", 1'b1, E_MW1);

    // Branch, taken and not taken: identical control in BRANCH.
    Op = 6'h04; Zero = 1'b1;
    cyc("t4_fetch_z1",  1'b1, E_F1);
    cyc("t4_decode_z1", 1'b1, E_DEC);
    cyc("t4_branch_z1", 1'b1, E_BR);
    Zero = 1'b0;
    cyc("t4_fetch_z0",  1'b1, E_F1);
    cyc("t4_decode_z0", 1'b1, E_DEC);
    cyc("t4_branch_z0", 1'b1, E_BR);

    // Jump, then an illegal opcode.
    Op = 6'h02;
    cyc("t5_fetch_j",  1'b1, E_F1);
    cyc("t5_decode_j", 1'b1, E_DEC);
    cyc("t5_jump",     1'b1, E_JMP);
    Op = 6'h3F;
    cyc("t5_fetch_ill",  1'b1, E_F1);
    cyc("t5_decode_ill", 1'b1, E_ILL);

    // R-type then ADDI back to back.
    Op = 6'h00;
    cyc("t6_fetch_r",  1'b1, E_F1);
    cyc("t6_decode_r", 1'b1, E_DEC);
    cyc("t6_exec_r",   1'b1, E_EXE);
    cyc("t6_wb_r",     1'b1, E_AWB);
    Op = 6'h08;
    cyc("t6_fetch_i",  1'b1, E_F1);
    cyc("t6_decode_i", 1'b1, E_DEC);
    cyc("t6_exec_i",   1'b1, E_ADR);
    cyc("t6_wb_i",     1'b1, E_IWB);
    cyc("t6_fetch_end", 1'b0, E_F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
